rob_3way: RTL



---
 rtl/rob_3way.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/rob_3way.sv
// rob_3way: 3-wide in-order reorder buffer between the 3-way rename stage and ARAT commit.
// Defining ROB_PERF_CNT_EN adds saturating retire and full-stall performance counters.
module rob_3way #(
    parameter int DEPTH  = 16,
    parameter int TAG_W  = 4,
    parameter int PREG_W = 5,
    parameter int AREG_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze_front,
    input  logic              valid_issue_x,
    input  logic              valid_issue_y,
    input  logic              valid_issue_z,
    input  logic [AREG_W-1:0] Rw_x,
    input  logic [AREG_W-1:0] Rw_y,
    input  logic [AREG_W-1:0] Rw_z,
    input  logic [PREG_W-1:0] Pw_x,
    input  logic [PREG_W-1:0] Pw_y,
    input  logic [PREG_W-1:0] Pw_z,
    input  logic [PREG_W-1:0] Pw_old_x,
    input  logic [PREG_W-1:0] Pw_old_y,
    input  logic [PREG_W-1:0] Pw_old_z,
    output logic [TAG_W-1:0]  tag_x,
    output logic [TAG_W-1:0]  tag_y,
    output logic [TAG_W-1:0]  tag_z,
    output logic              full_ROB,
    input  logic              cmp_valid_add,
    input  logic              cmp_valid_mul,
    input  logic [TAG_W-1:0]  cmp_tag_add,
    input  logic [TAG_W-1:0]  cmp_tag_mul,
    input  logic              cmp_exp_add,
    input  logic              cmp_exp_mul,
    output logic              RegWr_x,
    output logic              RegWr_y,
    output logic              RegWr_z,
    output logic              exp_x,
    output logic              exp_y,
    output logic              exp_z,
    output logic [PREG_W-1:0] Pw_retire_x,
    output logic [PREG_W-1:0] Pw_retire_y,
    output logic [PREG_W-1:0] Pw_retire_z,
    output logic [AREG_W-1:0] Rw_commit_x,
    output logic [AREG_W-1:0] Rw_commit_y,
    output logic [AREG_W-1:0] Rw_commit_z,
    output logic [PREG_W-1:0] Pw_commit_x,
    output logic [PREG_W-1:0] Pw_commit_y,
    output logic [PREG_W-1:0] Pw_commit_z,
    output logic              flush,
`ifdef ROB_PERF_CNT_EN
    output logic [31:0]       perf_retired,
    output logic [31:0]       perf_full_stall,
`endif
    output logic              empty_ROB
);

    localparam logic [TAG_W:0] FULL_LIMIT = (TAG_W+1)'(DEPTH - 3);

    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  done_q;
    logic [DEPTH-1:0]  exp_q;
    logic [AREG_W-1:0] rw_q     [DEPTH];
    logic [PREG_W-1:0] pw_q     [DEPTH];
    logic [PREG_W-1:0] pw_old_q [DEPTH];

    logic [TAG_W-1:0]  head;
    logic [TAG_W-1:0]  tail;
    logic [TAG_W:0]    count;

    logic              alloc_en;
    logic [1:0]        n_alloc;
    logic [1:0]        n_retire;
    logic [TAG_W-1:0]  h0;
    logic [TAG_W-1:0]  h1;
    logic [TAG_W-1:0]  h2;
    logic              elig0;
    logic              elig1;
    logic              elig2;
    logic              retire_exp;

    assign full_ROB  = count > FULL_LIMIT;
    assign empty_ROB = count == '0;
    assign alloc_en  = !freeze_front && !full_ROB && !flush;

    // Valid slots pack densely from tail; skipped slots consume no index.
    assign tag_x   = tail;
    assign tag_y   = tail + TAG_W'(valid_issue_x);
    assign tag_z   = tail + TAG_W'(valid_issue_x) + TAG_W'(valid_issue_y);
    assign n_alloc = alloc_en ? (2'(valid_issue_x) + 2'(valid_issue_y) + 2'(valid_issue_z)) : 2'd0;

    assign h0 = head;
    assign h1 = head + TAG_W'(1);
    assign h2 = head + TAG_W'(2);

    // An excepting entry still retires in its slot but blocks every younger slot.
    assign elig0 = !flush && valid_q[h0] && done_q[h0];
    assign elig1 = elig0 && !exp_q[h0] && valid_q[h1] && done_q[h1];
    assign elig2 = elig1 && !exp_q[h1] && valid_q[h2] && done_q[h2];

    assign n_retire   = 2'(elig0) + 2'(elig1) + 2'(elig2);
    assign retire_exp = (elig0 && exp_q[h0]) || (elig1 && exp_q[h1]) || (elig2 && exp_q[h2]);

    assign RegWr_x     = elig0 && (rw_q[h0] != '0);
    assign RegWr_y     = elig1 && (rw_q[h1] != '0);
    assign RegWr_z     = elig2 && (rw_q[h2] != '0);
    assign exp_x       = elig0 && exp_q[h0];
    assign exp_y       = elig1 && exp_q[h1];
    assign exp_z       = elig2 && exp_q[h2];
    assign Pw_retire_x = elig0 ? pw_old_q[h0] : '0;
    assign Pw_retire_y = elig1 ? pw_old_q[h1] : '0;
    assign Pw_retire_z = elig2 ? pw_old_q[h2] : '0;
    assign Rw_commit_x = elig0 ? rw_q[h0] : '0;
    assign Rw_commit_y = elig1 ? rw_q[h1] : '0;
    assign Rw_commit_z = elig2 ? rw_q[h2] : '0;
    assign Pw_commit_x = elig0 ? pw_q[h0] : '0;
    assign Pw_commit_y = elig1 ? pw_q[h1] : '0;
    assign Pw_commit_z = elig2 ? pw_q[h2] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            done_q  <= '0;
            exp_q   <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            flush   <= 1'b0;
        end else if (flush) begin
            valid_q <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            flush   <= 1'b0;
        end else begin
            flush <= retire_exp;
            head  <= head + TAG_W'(n_retire);
            tail  <= tail + TAG_W'(n_alloc);
            count <= count + (TAG_W+1)'(n_alloc) - (TAG_W+1)'(n_retire);
            if (elig0) valid_q[h0] <= 1'b0;
            if (elig1) valid_q[h1] <= 1'b0;
            if (elig2) valid_q[h2] <= 1'b0;
            if (cmp_valid_add && valid_q[cmp_tag_add]) begin
                done_q[cmp_tag_add] <= 1'b1;
                exp_q[cmp_tag_add]  <= exp_q[cmp_tag_add] | cmp_exp_add;
            end
            if (cmp_valid_mul && valid_q[cmp_tag_mul]) begin
                done_q[cmp_tag_mul] <= 1'b1;
                exp_q[cmp_tag_mul]  <= exp_q[cmp_tag_mul] | cmp_exp_mul;
            end
            // Allocation targets only free entries, so it never collides with retire or completion.
            if (alloc_en && valid_issue_x) begin
                valid_q[tag_x] <= 1'b1;
                done_q[tag_x]  <= 1'b0;
                exp_q[tag_x]   <= 1'b0;
            end
            if (alloc_en && valid_issue_y) begin
                valid_q[tag_y] <= 1'b1;
                done_q[tag_y]  <= 1'b0;
                exp_q[tag_y]   <= 1'b0;
            end
            if (alloc_en && valid_issue_z) begin
                valid_q[tag_z] <= 1'b1;
                done_q[tag_z]  <= 1'b0;
                exp_q[tag_z]   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_en && valid_issue_x) begin
            rw_q[tag_x]     <= Rw_x;
            pw_q[tag_x]     <= Pw_x;
            pw_old_q[tag_x] <= Pw_old_x;
        end
        if (alloc_en && valid_issue_y) begin
            rw_q[tag_y]     <= Rw_y;
            pw_q[tag_y]     <= Pw_y;
            pw_old_q[tag_y] <= Pw_old_y;
        end
        if (alloc_en && valid_issue_z) begin
            rw_q[tag_z]     <= Rw_z;
            pw_q[tag_z]     <= Pw_z;
            pw_old_q[tag_z] <= Pw_old_z;
        end
    end

`ifdef ROB_PERF_CNT_EN
    logic [32:0] retired_sum;
    logic        stall_cycle;

    assign retired_sum = {1'b0, perf_retired} + 33'(n_retire);
    assign stall_cycle = full_ROB && (valid_issue_x || valid_issue_y || valid_issue_z);

    // Counters saturate and survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_retired    <= '0;
            perf_full_stall <= '0;
        end else begin
            perf_retired <= retired_sum[32] ? '1 : retired_sum[31:0];
            if (stall_cycle && (perf_full_stall != '1)) perf_full_stall <= perf_full_stall + 32'd1;
        end
    end
`endif

endmodule
